// File: rtl/op_sram_drain_pkg.sv
// Shared constants and FSM encoding for the output-SRAM drain controller.
package op_sram_drain_pkg;

    localparam int OP_DEPTH = 16;
    localparam int OP_WIDTH = 128;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        FIN
    } state_e;

endpackage

// File: rtl/op_sram_drain_fifo.sv
// Small synchronous FIFO holding drained rows plus their last-row flag.
module op_drain_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 129,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     pop_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign pop_data = mem_q[rd_ptr_q];
    assign do_pop   = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full))
        else $error("op_drain_fifo: push into full FIFO");

endmodule

// File: rtl/op_sram_drain.sv
// Reads rows 0..n-1 of the output SRAM and streams them over valid/ready,
// absorbing the SRAM's one-cycle read latency with a small skid FIFO.
module op_sram_drain
    import op_sram_drain_pkg::*;
#(
    parameter int DEPTH      = OP_DEPTH,
    parameter int WIDTH      = OP_WIDTH,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              start,
    input  logic [ADDR_W:0]   num_rows,
    output logic              busy,
    output logic              done,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_a,
    input  logic [WIDTH-1:0]  sram_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_last
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W:0] N_MAX = DEPTH[ADDR_W:0];

    state_e          state_q, state_d;
    logic [ADDR_W:0] n_q, n_d;
    logic [ADDR_W:0] cnt_q, cnt_d;
    logic            pending_q, pending_d;
    logic            pend_last_q, pend_last_d;

    logic             issue;
    logic             issue_last;
    logic             pop;
    logic [WIDTH:0]   fifo_rd;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    op_drain_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (WIDTH + 1)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RSTN),
        .push      (pending_q),
        .push_data ({pend_last_q, sram_q}),
        .pop       (pop),
        .pop_data  (fifo_rd),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid  = !fifo_empty;
    assign out_data   = fifo_rd[WIDTH-1:0];
    assign out_last   = out_valid && fifo_rd[WIDTH];
    assign pop        = out_valid && out_ready;
    assign issue_last = (cnt_q == n_q - 1'b1);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= IDLE;
            n_q         <= '0;
            cnt_q       <= '0;
            pending_q   <= 1'b0;
            pend_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            pend_last_q <= pend_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        pending_d   = issue;
        pend_last_d = issue && issue_last;
        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d   = (num_rows > N_MAX) ? N_MAX : num_rows;
                    cnt_d = '0;
                    state_d = (num_rows == '0) ? FIN : READ;
                end
            end
            READ: begin
                if (issue) begin
                    cnt_d = cnt_q + 1'b1;
                    if (issue_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leave as soon as the final beat is handshaking, so done follows it directly.
                if (!pending_q && (fifo_empty || (fifo_count == CNT_W'(1) && pop))) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        issue    = (state_q == READ) && !fifo_full
                   && ((int'(fifo_count) + int'(pending_q)) <= FIFO_DEPTH - 1);
        busy     = (state_q == READ) || (state_q == DRAIN);
        done     = (state_q == FIN);
        sram_wen = 1'b1;
        sram_cen = !issue;
        sram_a   = issue ? cnt_q[ADDR_W-1:0] : '0;
    end

endmodule

// File: tb/tb_op_sram_drain.sv
// Scoreboard bench for op_sram_drain: directed transfers with a registered-read SRAM model.
module tb_op_sram_drain;

    localparam int DEPTH  = 16;
    localparam int WIDTH  = 128;
    localparam int ADDR_W = 4;

    logic              CLK;
    logic              RSTN;
    logic              start;
    logic [ADDR_W:0]   num_rows;
    logic              busy;
    logic              done;
    logic              sram_cen;
    logic              sram_wen;
    logic [ADDR_W-1:0] sram_a;
    logic [WIDTH-1:0]  sram_q;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic              out_last;

    op_sram_drain #(
        .DEPTH      (DEPTH),
        .WIDTH      (WIDTH),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (4)
    ) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .start     (start),
        .num_rows  (num_rows),
        .busy      (busy),
        .done      (done),
        .sram_cen  (sram_cen),
        .sram_wen  (sram_wen),
        .sram_a    (sram_a),
        .sram_q    (sram_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [WIDTH-1:0] mem [DEPTH];
    initial begin
        for (int k = 0; k < DEPTH; k++) mem[k] = WIDTH'(32'h1000 + k);
        sram_q = '0;
    end
    always @(posedge CLK) if (!sram_cen) sram_q <= mem[sram_a];

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [WIDTH:0] sb[$];

    int start_cyc = 0;
    int beats, reads, exp_addr, max_out;
    int first_beat, last_beat, done_cyc, reads_at_10;
    bit done_seen;
    bit prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data;
    logic prev_last;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on every handshake.
    always @(negedge CLK) begin
        if (!RSTN) begin
            prev_stall = 1'b0;
        end else begin
            if (!sram_cen) begin
                chk("sram_addr", WIDTH'(sram_a), WIDTH'(exp_addr));
                exp_addr++;
                reads++;
            end
            if (prev_stall) begin
                chk("stall_valid", WIDTH'(out_valid), WIDTH'(1));
                chk("stall_data", out_data, prev_data);
                chk("stall_last", WIDTH'(out_last), WIDTH'(prev_last));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected no beat", out_data);
                end else begin
                    logic [WIDTH:0] e;
                    e = sb.pop_front();
                    chk("beat_data", out_data, e[WIDTH-1:0]);
                    chk("beat_last", WIDTH'(out_last), WIDTH'(e[WIDTH]));
                end
                if (beats == 0) first_beat = cyc - start_cyc;
                last_beat = cyc - start_cyc;
                beats++;
            end
            if (reads - beats > max_out) max_out = reads - beats;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (done) begin
                done_seen = 1'b1;
                done_cyc  = cyc - start_cyc;
                chk("busy_at_done", WIDTH'(busy), WIDTH'(0));
                chk("sb_empty_at_done", WIDTH'(sb.size()), WIDTH'(0));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ready(input int mode, input int rel);
        logic [3:0] pat;
        pat = 4'b1001;
        case (mode)
            0: out_ready = 1'b1;
            1: out_ready = pat[rel % 4];
            default: out_ready = (rel >= 10);
        endcase
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},  WIDTH'(busy), WIDTH'(0));
        chk({tag, "_done"},  WIDTH'(done), WIDTH'(0));
        chk({tag, "_cen"},   WIDTH'(sram_cen), WIDTH'(1));
        chk({tag, "_wen"},   WIDTH'(sram_wen), WIDTH'(1));
        chk({tag, "_a"},     WIDTH'(sram_a), WIDTH'(0));
        chk({tag, "_valid"}, WIDTH'(out_valid), WIDTH'(0));
        chk({tag, "_last"},  WIDTH'(out_last), WIDTH'(0));
        chk({tag, "_data"},  out_data, '0);
    endtask

    // Called at posedge+1 of the cycle the start pulse is driven (relative cycle 0).
    task automatic run_xfer(input int nr, input int mode, input int mid_at, input int rst_at);
        int n;
        n = (nr > DEPTH) ? DEPTH : nr;
        beats = 0; reads = 0; exp_addr = 0; max_out = 0;
        first_beat = -1; last_beat = -1; done_cyc = -1; reads_at_10 = -1;
        done_seen = 1'b0;
        for (int k = 0; k < n; k++) sb.push_back({(k == n - 1), WIDTH'(32'h1000 + k)});
        start_cyc = cyc;
        start     = 1'b1;
        num_rows  = (ADDR_W + 1)'(nr);
        set_ready(mode, 0);
        for (int rel = 1; rel < 300 && !done_seen; rel++) begin
            tick();
            start = 1'b0;
            set_ready(mode, rel);
            if (rel == 1 && n > 0) chk("busy_cycle1", WIDTH'(busy), WIDTH'(1));
            if (rel == 10) reads_at_10 = reads;
            if (rel == mid_at) begin
                start    = 1'b1;
                num_rows = 5'd3;
            end
            if (rel == rst_at) begin
                RSTN = 1'b0;
                #1;
                check_reset_outputs("midrst");
                chk("rows_left_at_reset", WIDTH'(sb.size()), WIDTH'(10));
                sb.delete();
                break;
            end
        end
        if (rst_at < 0 && !done_seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done for num_rows=%0d", nr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        RSTN = 1'b0; start = 1'b0; num_rows = '0; out_ready = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        RSTN = 1'b1;
        tick();

        run_xfer(16, 0, -1, -1);
        chk("t1_beats", WIDTH'(beats), WIDTH'(16));
        chk("t1_first", WIDTH'(first_beat), WIDTH'(3));
        chk("t1_last", WIDTH'(last_beat), WIDTH'(18));
        chk("t1_done", WIDTH'(done_cyc), WIDTH'(19));
        chk("t1_reads", WIDTH'(reads), WIDTH'(16));

        tick();
        run_xfer(5, 1, -1, -1);
        chk("t2_beats", WIDTH'(beats), WIDTH'(5));
        chk("t2_reads", WIDTH'(reads), WIDTH'(5));
        checks++;
        if (max_out > 4) begin
            errors++;
            $display("FAIL t2_occupancy: got %0d expected <= 4", max_out);
        end

        tick();
        run_xfer(0, 0, -1, -1);
        chk("t3_zero_done", WIDTH'(done_cyc), WIDTH'(1));
        chk("t3_zero_reads", WIDTH'(reads), WIDTH'(0));
        chk("t3_zero_beats", WIDTH'(beats), WIDTH'(0));

        tick();
        run_xfer(20, 0, -1, -1);
        chk("t3_clamp_beats", WIDTH'(beats), WIDTH'(16));
        chk("t3_clamp_done", WIDTH'(done_cyc), WIDTH'(19));

        tick();
        run_xfer(8, 0, 5, -1);
        chk("t4_beats", WIDTH'(beats), WIDTH'(8));
        chk("t4_done", WIDTH'(done_cyc), WIDTH'(11));
        run_xfer(4, 0, -1, -1);
        chk("t4_b2b_first", WIDTH'(first_beat), WIDTH'(3));
        chk("t4_b2b_beats", WIDTH'(beats), WIDTH'(4));
        chk("t4_b2b_done", WIDTH'(done_cyc), WIDTH'(7));

        tick();
        run_xfer(16, 0, -1, 9);
        chk("t5_beats_before_reset", WIDTH'(beats), WIDTH'(6));
        tick();
        RSTN = 1'b1;
        tick();
        run_xfer(3, 0, -1, -1);
        chk("t5_after_beats", WIDTH'(beats), WIDTH'(3));
        chk("t5_after_done", WIDTH'(done_cyc), WIDTH'(6));

        tick();
        run_xfer(16, 2, -1, -1);
        chk("t6_reads_stalled", WIDTH'(reads_at_10), WIDTH'(4));
        chk("t6_first", WIDTH'(first_beat), WIDTH'(10));
        chk("t6_last", WIDTH'(last_beat), WIDTH'(25));
        chk("t6_done", WIDTH'(done_cyc), WIDTH'(26));
        chk("t6_beats", WIDTH'(beats), WIDTH'(16));

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
